wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 31 +++
 rtl/wb_regfile_regfile.sv | 52 +++++
 rtl/wb_regfile.sv | 86 ++++++++
 tb/tb_wb_regfile.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared pipeline constants and helpers.
// Imported by the writeback stage and the register array.
package wb_regfile_pkg;

    // Architectural data width and register count.
    localparam int XLEN = 32;
    localparam int NREG = 32;

    // Register index width and the hard-wired zero register.
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // A pending writeback can be forwarded to a reader only when it
    // is live and targets a real (non-zero) register.
    function automatic logic wb_hit(
        input logic                  en,
        input logic [REG_ADDR_W-1:0] wa,
        input logic [REG_ADDR_W-1:0] ra
    );
        return en && (wa == ra) && (ra != ZERO_REG);
    endfunction

    // A write commits only when live and not aimed at register zero.
    function automatic logic wr_live(
        input logic                  en,
        input logic [REG_ADDR_W-1:0] wa
    );
        return en && (wa != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_regfile_regfile.sv
// regfile: NREG x XLEN register array, 2 comb reads, 1 sync write.
// Ports: clock, reset (async low), we/waddr/wdata, raddr1/2 -> rdata1/2.
import wb_regfile_pkg::*;

module regfile #(
    parameter int XLEN = wb_regfile_pkg::XLEN,
    parameter int NREG = wb_regfile_pkg::NREG
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2
);

    logic [XLEN-1:0] mem [NREG];

    logic wr_ok;

    // Indices beyond NREG (when NREG < 32) are ignored on write.
    assign wr_ok = wr_live(we, waddr) && (int'(waddr) < NREG);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Register zero reads 0 explicitly, independent of array contents.
    always_comb begin
        rdata1 = '0;
        if (raddr1 != ZERO_REG && int'(raddr1) < NREG) begin
            rdata1 = mem[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != ZERO_REG && int'(raddr2) < NREG) begin
            rdata2 = mem[raddr2];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB pipeline register, register file and read bypass.
// Ports: clock, reset (async low), io_from_mem_*, io_stall, io_flush,
//        io_read{1,2}_addr -> io_read{1,2}_data, io_wb_* (for EX fwd).
import wb_regfile_pkg::*;

module wb_regfile #(
    parameter int XLEN = wb_regfile_pkg::XLEN,
    parameter int NREG = wb_regfile_pkg::NREG
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_from_mem_writeEnable,
    input  logic [REG_ADDR_W-1:0] io_from_mem_writeAddr,
    input  logic [XLEN-1:0]       io_from_mem_result,
    input  logic                  io_stall,
    input  logic                  io_flush,
    input  logic [REG_ADDR_W-1:0] io_read1_addr,
    input  logic [REG_ADDR_W-1:0] io_read2_addr,
    output logic [XLEN-1:0]       io_read1_data,
    output logic [XLEN-1:0]       io_read2_data,
    output logic                  io_wb_writeEnable,
    output logic [REG_ADDR_W-1:0] io_wb_writeAddr,
    output logic [XLEN-1:0]       io_wb_result
);

    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]       wb_data;

    logic [XLEN-1:0]       rf_rd1;
    logic [XLEN-1:0]       rf_rd2;

    // Flush beats stall; a flushed slot is fully zeroed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (io_flush) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (!io_stall) begin
            wb_en   <= io_from_mem_writeEnable;
            wb_addr <= io_from_mem_writeAddr;
            wb_data <= io_from_mem_result;
        end
    end

    assign io_wb_writeEnable = wb_en;
    assign io_wb_writeAddr   = wb_addr;
    assign io_wb_result      = wb_data;

    // The array is written from the MEM/WB slot; a held slot under
    // stall simply rewrites the same value each cycle.
    regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (io_read1_addr),
        .raddr2 (io_read2_addr),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    // Write-through bypass: readers see the slot before it lands.
    always_comb begin
        io_read1_data = rf_rd1;
        if (wb_hit(wb_en, wb_addr, io_read1_addr)) begin
            io_read1_data = wb_data;
        end
    end

    always_comb begin
        io_read2_data = rf_rd2;
        if (wb_hit(wb_en, wb_addr, io_read2_addr)) begin
            io_read2_data = wb_data;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
// Linear stimulus; expected values are hand-computed constants.
module tb_wb_regfile;

    logic        clock;
    logic        reset;
    logic        mem_we;
    logic [4:0]  mem_wa;
    logic [31:0] mem_res;
    logic        stall;
    logic        flush;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_res;

    int n_cmp;
    int n_bad;

    wb_regfile dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_from_mem_writeEnable (mem_we),
        .io_from_mem_writeAddr   (mem_wa),
        .io_from_mem_result      (mem_res),
        .io_stall                (stall),
        .io_flush                (flush),
        .io_read1_addr           (ra1),
        .io_read2_addr           (ra2),
        .io_read1_data           (rd1),
        .io_read2_data           (rd2),
        .io_wb_writeEnable       (wb_we),
        .io_wb_writeAddr         (wb_wa),
        .io_wb_result            (wb_res)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        mem_we  = 1'b0;
        mem_wa  = 5'd0;
        mem_res = 32'h0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        ra1   = 5'd5;
        ra2   = 5'd5;
        idle();

        // Reset state
        #2;
        chk("rst_wb_we",  {31'b0, wb_we}, 32'h0);
        chk("rst_wb_wa",  {27'b0, wb_wa}, 32'h0);
        chk("rst_wb_res", wb_res, 32'h0);
        chk("rst_rd1",    rd1, 32'h0);
        chk("rst_rd2",    rd2, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Write then read: bypass, then storage
        mem_we  = 1'b1;
        mem_wa  = 5'd5;
        mem_res = 32'hDEADBEEF;
        tick();
        chk("wr_wb_we",  {31'b0, wb_we}, 32'h1);
        chk("wr_wb_wa",  {27'b0, wb_wa}, 32'd5);
        chk("wr_wb_res", wb_res, 32'hDEADBEEF);
        idle();
        #1;
        chk("wr_bypass", rd1, 32'hDEADBEEF);
        tick();
        chk("wr_wb_we_off", {31'b0, wb_we}, 32'h0);
        chk("wr_stored", rd1, 32'hDEADBEEF);

        // Register zero guard
        mem_we  = 1'b1;
        mem_wa  = 5'd0;
        mem_res = 32'hFFFFFFFF;
        ra1     = 5'd0;
        ra2     = 5'd0;
        #1;
        chk("z_pre_rd1", rd1, 32'h0);
        tick();
        chk("z_wb_we", {31'b0, wb_we}, 32'h1);
        chk("z_rd1", rd1, 32'h0);
        chk("z_rd2", rd2, 32'h0);
        idle();
        tick();
        chk("z_post_rd1", rd1, 32'h0);
        chk("z_post_rd2", rd2, 32'h0);

        // Stall holds, flush beats stall
        mem_we  = 1'b1;
        mem_wa  = 5'd3;
        mem_res = 32'h11;
        tick();
        chk("st_cap_wa",  {27'b0, wb_wa}, 32'd3);
        chk("st_cap_res", wb_res, 32'h11);
        mem_wa  = 5'd4;
        mem_res = 32'h22;
        stall   = 1'b1;
        ra1     = 5'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_hold_we",  {31'b0, wb_we}, 32'h1);
            chk("st_hold_wa",  {27'b0, wb_wa}, 32'd3);
            chk("st_hold_res", wb_res, 32'h11);
            chk("st_hold_rd1", rd1, 32'h11);
        end
        flush = 1'b1;
        tick();
        chk("fl_we",  {31'b0, wb_we}, 32'h0);
        chk("fl_wa",  {27'b0, wb_wa}, 32'h0);
        chk("fl_res", wb_res, 32'h0);
        stall = 1'b0;
        flush = 1'b0;
        idle();
        tick();
        ra1 = 5'd4;
        ra2 = 5'd3;
        #1;
        chk("fl_r4_unwritten", rd1, 32'h0);
        chk("fl_r3_stored",    rd2, 32'h11);

        // Back-to-back writes to the same register
        ra1     = 5'd7;
        ra2     = 5'd7;
        mem_we  = 1'b1;
        mem_wa  = 5'd7;
        mem_res = 32'h1;
        tick();
        chk("b2b_1", rd1, 32'h1);
        mem_res = 32'h2;
        tick();
        chk("b2b_2", rd1, 32'h2);
        mem_res = 32'h3;
        tick();
        chk("b2b_3", rd1, 32'h3);
        idle();
        tick();
        tick();
        chk("b2b_store_rd1", rd1, 32'h3);
        chk("b2b_store_rd2", rd2, 32'h3);

        // Fill r1..r31 with their own index
        for (int i = 1; i < 32; i++) begin
            mem_we  = 1'b1;
            mem_wa  = 5'(i);
            mem_res = 32'(i);
            tick();
        end
        idle();
        tick();
        for (int i = 1; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(32 - i);
            #1;
            chk("fill_rd1", rd1, 32'(i));
            chk("fill_rd2", rd2, 32'(32 - i));
        end

        // Async reset mid-operation aborts a pending write
        @(posedge clock);
        #1;
        mem_we  = 1'b1;
        mem_wa  = 5'd9;
        mem_res = 32'h99;
        tick();
        chk("ar_pending_we", {31'b0, wb_we}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_wb_we",  {31'b0, wb_we}, 32'h0);
        chk("ar_wb_wa",  {27'b0, wb_wa}, 32'h0);
        chk("ar_wb_res", wb_res, 32'h0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            chk("ar_rd1", rd1, 32'h0);
            chk("ar_rd2", rd2, 32'h0);
        end
        idle();
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("ar_post_we", {31'b0, wb_we}, 32'h0);
        tick();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(i);
            #1;
            chk("ar_post_rd1", rd1, 32'h0);
            chk("ar_post_rd2", rd2, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
